csr_file_m: RTL and testbench

Parametrised machine-mode CSR file for the npc core. It supersedes the fixed four-register CSR block. It adds mscratch, mie, mip, vectored mtvec, read-modify-write ops, trap entry and mret sequencing, interrupt arbitration, and optional cycle/instret counters. It sits beside the regfile and is read in EX, written at commit, and drives the redirect target to IF.

---
 rtl/csr_file_m.sv | 202 ++++++++++++++++++++
 tb/tb_csr_file_m.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file_m.sv
//==============================================================================
// csr_file_m : machine-mode CSR file (mstatus/mie/mtvec/mscratch/mepc/mcause/mip),
//              trap entry, mret, interrupt arbitration. Optional mcycle/minstret
//              counters enabled by `define CSR_COUNTERS_EN.   Revision: 1.0
//==============================================================================
`default_nettype none

module csr_file_m #(
    parameter int unsigned XLEN        = 64,
    parameter logic [63:0] MTVEC_RST   = 64'h0,
    parameter logic [63:0] MEPC_RST    = 64'h8000_0000,
    parameter logic [63:0] MSTATUS_RST = 64'h1800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_idx,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            instr_retire,
    input  logic            msip_i,
    input  logic            mtip_i,
    input  logic            meip_i,
    output logic [XLEN-1:0] redirect_pc,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    output logic            gIntEn
);

    localparam logic [11:0] C_MSTATUS  = 12'h300;
    localparam logic [11:0] C_MIE      = 12'h304;
    localparam logic [11:0] C_MTVEC    = 12'h305;
    localparam logic [11:0] C_MSCRATCH = 12'h340;
    localparam logic [11:0] C_MEPC     = 12'h341;
    localparam logic [11:0] C_MCAUSE   = 12'h342;
    localparam logic [11:0] C_MIP      = 12'h344;
    localparam logic [11:0] C_MCYCLE   = 12'hB00;
    localparam logic [11:0] C_MINSTRET = 12'hB02;

    localparam logic [1:0] C_OP_RW = 2'd1;
    localparam logic [1:0] C_OP_RS = 2'd2;
    localparam logic [1:0] C_OP_RC = 2'd3;

    localparam logic [XLEN-1:0] C_MIE_MASK  = XLEN'(64'h888);
    localparam logic [XLEN-1:0] C_MST_WMASK = XLEN'(64'h88);
    localparam logic [XLEN-1:0] C_MPP       = XLEN'(64'h1800);

    logic            mst_mie_q, mst_mie_d;
    logic            mst_mpie_q, mst_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef CSR_COUNTERS_EN
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
`endif

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_pend;
    logic [XLEN-1:0] w_wval;
    logic [XLEN-1:0] w_base;
    logic [3:0]      w_code;
    logic            w_impl;
    logic            w_wr_en;

    always_comb begin
        w_mstatus    = (MSTATUS_RST[XLEN-1:0] & ~C_MST_WMASK) | C_MPP;
        w_mstatus[3] = mst_mie_q;
        w_mstatus[7] = mst_mpie_q;
        w_mip        = '0;
        w_mip[3]     = msip_i;
        w_mip[7]     = mtip_i;
        w_mip[11]    = meip_i;
    end

    always_comb begin
        w_impl    = 1'b1;
        csr_rdata = '0;
        case (csr_idx)
            C_MSTATUS:  csr_rdata = w_mstatus;
            C_MIE:      csr_rdata = mie_q;
            C_MTVEC:    csr_rdata = mtvec_q;
            C_MSCRATCH: csr_rdata = mscratch_q;
            C_MEPC:     csr_rdata = mepc_q;
            C_MCAUSE:   csr_rdata = mcause_q;
            C_MIP:      csr_rdata = w_mip;
`ifdef CSR_COUNTERS_EN
            C_MCYCLE:   csr_rdata = mcycle_q;
            C_MINSTRET: csr_rdata = minstret_q;
`endif
            default:    w_impl = 1'b0;
        endcase
    end

    assign csr_illegal = (csr_op != 2'd0) && !w_impl;
    // Writes to mip fall through the write case below and are silently dropped.
    assign w_wr_en     = (csr_op != 2'd0) && w_impl && !trap_valid && !mret_valid;

    always_comb begin
        case (csr_op)
            C_OP_RW: w_wval = csr_wdata;
            C_OP_RS: w_wval = csr_rdata | csr_wdata;
            C_OP_RC: w_wval = csr_rdata & ~csr_wdata;
            default: w_wval = csr_rdata;
        endcase
    end

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
`ifdef CSR_COUNTERS_EN
        mcycle_d   = mcycle_q + {{(XLEN-1){1'b0}}, 1'b1};
        minstret_d = minstret_q + {{(XLEN-1){1'b0}}, instr_retire};
`endif
        if (trap_valid) begin
            mepc_d     = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d   = trap_cause;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (mret_valid) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (w_wr_en) begin
            case (csr_idx)
                C_MSTATUS: begin
                    mst_mie_d  = w_wval[3];
                    mst_mpie_d = w_wval[7];
                end
                C_MIE:      mie_d      = w_wval & C_MIE_MASK;
                // Reserved MODE encodings (2/3) leave the current mode in place.
                C_MTVEC:    mtvec_d    = {w_wval[XLEN-1:2], w_wval[1] ? mtvec_q[1:0] : w_wval[1:0]};
                C_MSCRATCH: mscratch_d = w_wval;
                C_MEPC:     mepc_d     = {w_wval[XLEN-1:2], 2'b00};
                C_MCAUSE:   mcause_d   = w_wval;
`ifdef CSR_COUNTERS_EN
                C_MCYCLE:   mcycle_d   = w_wval;
                C_MINSTRET: minstret_d = w_wval;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mst_mie_q  <= MSTATUS_RST[3];
            mst_mpie_q <= MSTATUS_RST[7];
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST[XLEN-1:0];
            mscratch_q <= '0;
            mepc_q     <= MEPC_RST[XLEN-1:0];
            mcause_q   <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    assign w_base      = {mtvec_q[XLEN-1:2], 2'b00};
    assign redirect_pc = !trap_valid ? mepc_q :
                         (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1]) ?
                         w_base + {{(XLEN-8){1'b0}}, trap_cause[5:0], 2'b00} : w_base;

    assign w_pend  = w_mip & mie_q;
    assign w_code  = w_pend[11] ? 4'd11 : w_pend[3] ? 4'd3 : w_pend[7] ? 4'd7 : 4'd0;
    assign irq_req   = mst_mie_q && (w_pend != '0);
    assign irq_cause = {1'b1, {(XLEN-5){1'b0}}, w_code};
    assign gIntEn    = mst_mie_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_file_m.sv
//==============================================================================
// tb_csr_file_m : scoreboard bench for csr_file_m against a CSR reference model.
//==============================================================================
`default_nettype none

module tb_csr_file_m;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] csr_idx = '0;
    logic [1:0]  csr_op = '0;
    logic [63:0] csr_wdata = '0;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_cause = '0;
    logic [63:0] trap_pc = '0;
    logic        mret_valid = 1'b0;
    logic        instr_retire = 1'b0;
    logic        msip_i = 1'b0, mtip_i = 1'b0, meip_i = 1'b0;
    logic [63:0] redirect_pc;
    logic        irq_req;
    logic [63:0] irq_cause;
    logic        gIntEn;

    csr_file_m dut (
        .clk(clk), .rst(rst), .csr_idx(csr_idx), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .mret_valid(mret_valid),
        .instr_retire(instr_retire), .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i),
        .redirect_pc(redirect_pc), .irq_req(irq_req), .irq_cause(irq_cause), .gIntEn(gIntEn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        ill;
        logic [63:0] redir;
        logic        irq;
        logic [63:0] icause;
        logic        gie;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err = 0;

    // Reference architectural state
    logic        m_mie_b, m_mpie_b;
    logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_mie_b = 1'b0; m_mpie_b = 1'b0;
        m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 64'h8000_0000; m_mcause = 0;
        m_mcycle = 0; m_minstret = 0;
    endfunction

    function automatic logic m_legal(input logic [11:0] idx);
        case (idx)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344: return 1'b1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB02: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] idx, input logic [63:0] mip);
        case (idx)
            12'h300: return 64'h1800 | (64'(m_mpie_b) << 7) | (64'(m_mie_b) << 3);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return mip;
`ifdef CSR_COUNTERS_EN
            12'hB00: return m_mcycle;
            12'hB02: return m_minstret;
`endif
            default: return 64'h0;
        endcase
    endfunction

    // Apply one cycle: returns the outputs expected during the cycle, then advances state.
    task automatic drive(input int op, input logic [11:0] idx, input logic [63:0] wd,
                         input logic tv, input logic [63:0] tc, input logic [63:0] tp,
                         input logic mv, input logic ret, input logic [2:0] irqs);
        exp_t        e;
        logic [63:0] mip, old, nv, pend;
        @(posedge clk);
        #1;
        csr_op = 2'(op); csr_idx = idx; csr_wdata = wd;
        trap_valid = tv; trap_cause = tc; trap_pc = tp; mret_valid = mv;
        instr_retire = ret; meip_i = irqs[2]; mtip_i = irqs[1]; msip_i = irqs[0];
        mip  = (64'(irqs[2]) << 11) | (64'(irqs[1]) << 7) | (64'(irqs[0]) << 3);
        old  = m_read(idx, mip);
        pend = mip & m_mie;
        e.rdata = old;
        e.ill   = (op != 0) && !m_legal(idx);
        if (tv)
            e.redir = (m_mtvec & ~64'h3) +
                      ((m_mtvec[1:0] == 2'b01 && tc[63]) ? 64'(tc[5:0]) * 4 : 64'h0);
        else
            e.redir = m_mepc;
        e.irq    = m_mie_b && (pend != 0);
        e.icause = 64'h8000_0000_0000_0000 |
                   (pend[11] ? 64'd11 : pend[3] ? 64'd3 : pend[7] ? 64'd7 : 64'd0);
        e.gie    = m_mie_b;
        q.push_back(e);

        case (op)
            1: nv = wd;
            2: nv = old | wd;
            3: nv = old & ~wd;
            default: nv = old;
        endcase
        m_mcycle = m_mcycle + 1;
        if (ret) m_minstret = m_minstret + 1;
        if (tv) begin
            m_mepc = tp & ~64'h3; m_mcause = tc; m_mpie_b = m_mie_b; m_mie_b = 1'b0;
        end else if (mv) begin
            m_mie_b = m_mpie_b; m_mpie_b = 1'b1;
        end else if (op != 0 && m_legal(idx)) begin
            case (idx)
                12'h300: begin m_mie_b = nv[3]; m_mpie_b = nv[7]; end
                12'h304: m_mie = nv & 64'h888;
                12'h305: m_mtvec = {nv[63:2], (nv[1:0] >= 2) ? m_mtvec[1:0] : nv[1:0]};
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~64'h3;
                12'h342: m_mcause = nv;
                12'hB00: m_mcycle = nv;
                12'hB02: m_minstret = nv;
                default: ;
            endcase
        end
    endtask

    task automatic idle_rd(input logic [11:0] idx, input logic [2:0] irqs);
        drive(0, idx, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, irqs);
    endtask

    task automatic wr(input int op, input logic [11:0] idx, input logic [63:0] wd);
        drive(op, idx, wd, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 3'b000);
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk64("rdata", csr_rdata, e.rdata);
                chk64("illegal", 64'(csr_illegal), 64'(e.ill));
                chk64("redirect_pc", redirect_pc, e.redir);
                chk64("irq_req", 64'(irq_req), 64'(e.irq));
                if (e.irq) chk64("irq_cause", irq_cause, e.icause);
                chk64("gIntEn", 64'(gIntEn), 64'(e.gie));
            end
        end
    end

    initial begin
        logic [11:0] addrs [10];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
                  12'hB00, 12'hB02, 12'h7C0};
        m_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        idle_rd(12'h300, 3'b000);
        idle_rd(12'h341, 3'b000);
        idle_rd(12'h305, 3'b000);
        idle_rd(12'h344, 3'b111);

        wr(1, 12'h340, 64'hF0);
        wr(2, 12'h340, 64'h0F);
        wr(3, 12'h340, 64'h3C);
        idle_rd(12'h340, 3'b000);

        wr(1, 12'h305, 64'h1001);
        wr(2, 12'h300, 64'h8);
        wr(1, 12'h304, 64'h80);
        idle_rd(12'h344, 3'b010);
        drive(0, 12'h341, 0, 1'b1, 64'h8000_0000_0000_0007, 64'h8000_0106, 1'b0, 1'b0, 3'b010);
        idle_rd(12'h341, 3'b010);
        idle_rd(12'h300, 3'b010);
        drive(0, 12'h341, 0, 1'b0, 0, 0, 1'b1, 1'b0, 3'b010);
        idle_rd(12'h300, 3'b010);
        drive(1, 12'h341, 64'h1234, 1'b1, 64'h2, 64'h2226, 1'b1, 1'b0, 3'b101);
        idle_rd(12'h341, 3'b101);
        idle_rd(12'h300, 3'b101);

        wr(1, 12'h305, 64'h2003);
        idle_rd(12'h305, 3'b000);
        wr(1, 12'h304, '1);
        wr(1, 12'h300, '1);
        idle_rd(12'h304, 3'b111);
        idle_rd(12'h300, 3'b111);
        wr(1, 12'h344, '1);
        idle_rd(12'h344, 3'b000);
        wr(1, 12'h7C0, 64'h55);

        wr(1, 12'hB00, '1);
        idle_rd(12'hB00, 3'b000);
        idle_rd(12'hB00, 3'b000);
        drive(1, 12'hB02, 64'h5, 1'b0, 0, 0, 1'b0, 1'b1, 3'b000);
        idle_rd(12'hB02, 3'b000);

        for (int i = 0; i < 400; i++) begin
            int          r = int'($urandom_range(0, 15));
            logic [63:0] tc = {1'($urandom_range(0, 1)), 59'h0, 4'($urandom_range(0, 15))};
            drive(int'($urandom_range(0, 3)), addrs[$urandom_range(0, 9)],
                  {$urandom, $urandom}, r == 0, tc, {$urandom, $urandom}, r == 1,
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        // Asynchronous reset mid-cycle: values must appear without a clock edge.
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        csr_op = 2'd0; trap_valid = 1'b0; mret_valid = 1'b0;
        msip_i = 1'b1; mtip_i = 1'b1; meip_i = 1'b1;
        csr_idx = 12'h341;
        #2 rst = 1'b1;
        #1 chk64("rst_mepc", csr_rdata, 64'h8000_0000);
        chk64("rst_irq_req", 64'(irq_req), 64'h0);
        csr_idx = 12'h300;
        #1 chk64("rst_mstatus", csr_rdata, 64'h1800);
        @(negedge clk);
        #1 rst = 1'b0;
        m_reset();
        idle_rd(12'h304, 3'b111);
        idle_rd(12'h340, 3'b000);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
